ctrl_pipe: RTL
==============

// Module: ctrl_pipe
// PURPOSE
//  Carries decoded IE/MEM/WB control words from decode through the ID/EX, EX/MEM and MEM/WB
//  pipeline registers. Consumes the decoder's control-word outputs and delivers them to each stage.
//  Handles stalls, flushes and bubble insertion, and detects load-use hazards. Counts inserted bubbles.
// PARAMETERS
//  IE_W   32  IE control word width (`IE_CTRL_SIZE)
//  MEM_W  32  MEM control word width (`MEM_CTRL_SIZE)
//  WB_W   32  WB control word width (`WB_CTRL_SIZE)
//  CNT_W  16  bubble counter width
// PORTS
//  clk            in   1      clock; all state updates on posedge
//  rst            in   1      synchronous, active-high reset
//  id_valid       in   1      decode-stage instruction valid
//  id_ie_ctrl     in   IE_W   IE control word from decoder
//  id_mem_ctrl    in   MEM_W  MEM control word from decoder
//  id_wb_ctrl     in   WB_W   WB control word from decoder
//  id_dest        in   5      destination register index
//  id_reg_write   in   1      instruction writes a register
//  id_mem_read    in   1      instruction is a load
//  id_src_a       in   5      source register A (rs)
//  id_src_b       in   5      source register B (rt)
//  id_uses_b      in   1      src_b is actually read
//  ex_flush       in   1      taken branch/jump resolved in EX: kill the ID instruction
//  mem_stall      in   1      memory wait: freeze all stage registers
//  stall_id       out  1      load-use interlock: upstream holds PC and IF/ID
//  ex_valid, ex_ie_ctrl, ex_mem_ctrl, ex_wb_ctrl, ex_dest         out  1/IE_W/MEM_W/WB_W/5
//  mem_valid, mem_mem_ctrl, mem_wb_ctrl, mem_dest                 out  1/MEM_W/WB_W/5
//  wb_valid, wb_wb_ctrl, wb_dest                                  out  1/WB_W/5
//  wb_reg_write   out  1      qualified register-file write enable
//  bubble_cnt     out  CNT_W  count of inserted bubbles, saturating
// BEHAVIOUR
//  - Reset: every valid, ctrl, dest and internal reg_write/mem_read flag clears to 0.
//    bubble_cnt=0. stall_id=0.
//  - Latency: ID->EX, EX->MEM and MEM->WB take 1 cycle each. An instruction is presented at wb_* 3 cycles after ID capture.
//  - Per-edge priority: rst > mem_stall > ex_flush > stall_id > normal advance.
//  - mem_stall=1: all three stage registers and bubble_cnt hold.
//    ex_flush and stall_id are ignored that cycle. The EX branch is held, so its flush re-asserts afterwards.
//  - ex_flush=1 (no mem_stall): ID/EX loads a bubble. EX->MEM and MEM->WB advance normally.
//  - stall_id=1 (no mem_stall/flush): ID/EX loads a bubble and the downstream stages advance.
//    The ID instruction is re-presented the next cycle.
//  - Bubble: valid=0, all ctrl words 0, dest=0, reg_write=0, mem_read=0.
//    id_valid=0 also captures a bubble, but does not count.
//  - stall_id is combinational from the registered EX state and the ID inputs. It is asserted when all of these hold:
//    ex_valid & ex_mem_read & ex_dest!=0 & id_valid & (ex_dest==id_src_a | id_uses_b & ex_dest==id_src_b).
//  - wb_reg_write = wb_valid & wb_reg_write_flag & (wb_dest!=0). Writes to $0 are never enabled.
//  - bubble_cnt increments by 1 on each edge where ID/EX takes a bubble due to ex_flush or stall_id.
//    Once it reaches all-ones it holds.
//  - Control words pass through bit-exact. The block never interprets ctrl word contents.
//  - Reset mid-stall or mid-flush: reset wins, and all state clears on that edge.
// STRUCTURE
//  - ctrl_pipe_pkg: ex_stage_t / mem_stage_t / wb_stage_t packed structs
//    (valid, ctrl words, dest, reg_write, mem_read), BUBBLE_* constants, REG_ZERO=5'd0.
//  - Sub-module ctrl_pipe_hazard: combinational load-use compare producing stall_id.
//  - Stage registers and the counter live in ctrl_pipe.
// TESTING
//  1. rst high 2 cycles with random inputs -> every output 0, stall_id=0, bubble_cnt=0.
//  2. ADD (ie=0x04, wb=0x03, dest=5, reg_write=1) for one cycle ->
//     ex_ie_ctrl=0x04 at +1, mem_dest=5 at +2, wb_dest=5 and wb_reg_write=1 at +3.
//  3. LW (ie=0x29, mem=0x29, mem_read=1, dest=8), then ID src_a=8 ->
//     stall_id=1 for 1 cycle, ex_valid=0 next, bubble_cnt=1; instruction enters EX the cycle after.
//  4. LW to dest=0 followed by a use of $0 -> stall_id=0. ALU to dest=0 -> wb_reg_write=0 at +3.
//  5. ex_flush=1 with valid ID (ie=0x34) -> ex_valid=0 and ex ctrl=0 next cycle;
//     the prior EX instruction appears in mem_*; bubble_cnt+1.
//  6. mem_stall=1 for 3 cycles with ex_flush=1 -> stage regs and bubble_cnt unchanged;
//     on release the flush is applied. With CNT_W=2, force 5 bubbles -> bubble_cnt stays 3.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared widths, stage payload structs and bubble constants for the control pipeline.
package ctrl_pipe_pkg;

  localparam int unsigned IE_W      = 32;
  localparam int unsigned MEM_W     = 32;
  localparam int unsigned WB_W      = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned CNT_W_DEF = 16;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // ID/EX payload: carries every control word plus the hazard-relevant flags
  typedef struct packed {
    logic             valid;
    logic [IE_W-1:0]  ie_ctrl;
    logic [MEM_W-1:0] mem_ctrl;
    logic [WB_W-1:0]  wb_ctrl;
    logic [REG_W-1:0] dest;
    logic             reg_write;
    logic             mem_read;
  } ex_stage_t;

  // EX/MEM payload: IE word has been consumed, load flag no longer needed
  typedef struct packed {
    logic             valid;
    logic [MEM_W-1:0] mem_ctrl;
    logic [WB_W-1:0]  wb_ctrl;
    logic [REG_W-1:0] dest;
    logic             reg_write;
  } mem_stage_t;

  // MEM/WB payload: only what the register-file write needs
  typedef struct packed {
    logic             valid;
    logic [WB_W-1:0]  wb_ctrl;
    logic [REG_W-1:0] dest;
    logic             reg_write;
  } wb_stage_t;

  localparam ex_stage_t  BUBBLE_EX  = '0;
  localparam mem_stage_t BUBBLE_MEM = '0;
  localparam wb_stage_t  BUBBLE_WB  = '0;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decode-to-pipeline bus: decoder control words in, per-stage control words out.
interface ctrl_pipe_if import ctrl_pipe_pkg::*; #(
  parameter int unsigned CNT_W = CNT_W_DEF
) ();

  logic             id_valid;
  logic [IE_W-1:0]  id_ie_ctrl;
  logic [MEM_W-1:0] id_mem_ctrl;
  logic [WB_W-1:0]  id_wb_ctrl;
  logic [REG_W-1:0] id_dest;
  logic             id_reg_write;
  logic             id_mem_read;
  logic [REG_W-1:0] id_src_a;
  logic [REG_W-1:0] id_src_b;
  logic             id_uses_b;
  logic             ex_flush;
  logic             mem_stall;

  logic             stall_id;
  logic             ex_valid;
  logic [IE_W-1:0]  ex_ie_ctrl;
  logic [MEM_W-1:0] ex_mem_ctrl;
  logic [WB_W-1:0]  ex_wb_ctrl;
  logic [REG_W-1:0] ex_dest;
  logic             mem_valid;
  logic [MEM_W-1:0] mem_mem_ctrl;
  logic [WB_W-1:0]  mem_wb_ctrl;
  logic [REG_W-1:0] mem_dest;
  logic             wb_valid;
  logic [WB_W-1:0]  wb_wb_ctrl;
  logic [REG_W-1:0] wb_dest;
  logic             wb_reg_write;
  logic [CNT_W-1:0] bubble_cnt;

  // Decoder / pipeline-control side
  modport master (
    output id_valid, id_ie_ctrl, id_mem_ctrl, id_wb_ctrl, id_dest, id_reg_write,
           id_mem_read, id_src_a, id_src_b, id_uses_b, ex_flush, mem_stall,
    input  stall_id, ex_valid, ex_ie_ctrl, ex_mem_ctrl, ex_wb_ctrl, ex_dest,
           mem_valid, mem_mem_ctrl, mem_wb_ctrl, mem_dest,
           wb_valid, wb_wb_ctrl, wb_dest, wb_reg_write, bubble_cnt
  );

  // Control pipeline side
  modport slave (
    input  id_valid, id_ie_ctrl, id_mem_ctrl, id_wb_ctrl, id_dest, id_reg_write,
           id_mem_read, id_src_a, id_src_b, id_uses_b, ex_flush, mem_stall,
    output stall_id, ex_valid, ex_ie_ctrl, ex_mem_ctrl, ex_wb_ctrl, ex_dest,
           mem_valid, mem_mem_ctrl, mem_wb_ctrl, mem_dest,
           wb_valid, wb_wb_ctrl, wb_dest, wb_reg_write, bubble_cnt
  );

endinterface

// File: rtl/ctrl_pipe_hazard.sv
// Load-use interlock: a load in EX whose destination feeds the ID instruction.
module ctrl_pipe_hazard import ctrl_pipe_pkg::*; (
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src_a,
  input  logic [REG_W-1:0] id_src_b,
  input  logic             id_uses_b,
  output logic             stall_id_c
);

  logic src_match;

  // src_b only matters when the instruction actually reads it
  assign src_match  = (ex_dest == id_src_a) || (id_uses_b && (ex_dest == id_src_b));

  // $0 is never a real producer, so loads into it never interlock
  assign stall_id_c = ex_valid && ex_mem_read && (ex_dest != REG_ZERO) && id_valid && src_match;

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control-word pipeline with stall, flush and bubble counting.
// Control-word widths are fixed by ctrl_pipe_pkg; only the counter width is a parameter.
module ctrl_pipe import ctrl_pipe_pkg::*; #(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  ctrl_pipe_if.slave  bus
);

  ex_stage_t        ex_q;
  ex_stage_t        id_entry;
  mem_stage_t       mem_q;
  wb_stage_t        wb_q;
  logic [CNT_W-1:0] bubble_q;
  logic             stall_id_c;

  ctrl_pipe_hazard u_hazard (
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.mem_read),
    .ex_dest     (ex_q.dest),
    .id_valid    (bus.id_valid),
    .id_src_a    (bus.id_src_a),
    .id_src_b    (bus.id_src_b),
    .id_uses_b   (bus.id_uses_b),
    .stall_id_c  (stall_id_c)
  );

  // Candidate ID/EX payload; an invalid decode slot becomes a clean bubble
  always_comb begin
    id_entry = BUBBLE_EX;
    if (bus.id_valid) begin
      id_entry.valid     = 1'b1;
      id_entry.ie_ctrl   = bus.id_ie_ctrl;
      id_entry.mem_ctrl  = bus.id_mem_ctrl;
      id_entry.wb_ctrl   = bus.id_wb_ctrl;
      id_entry.dest      = bus.id_dest;
      id_entry.reg_write = bus.id_reg_write;
      id_entry.mem_read  = bus.id_mem_read;
    end
  end

  // Stage registers and bubble counter: reset > mem_stall > flush/interlock > advance
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q     <= BUBBLE_EX;
      mem_q    <= BUBBLE_MEM;
      wb_q     <= BUBBLE_WB;
      bubble_q <= '0;
    end else if (!bus.mem_stall) begin
      mem_q <= '{valid:     ex_q.valid,
                 mem_ctrl:  ex_q.mem_ctrl,
                 wb_ctrl:   ex_q.wb_ctrl,
                 dest:      ex_q.dest,
                 reg_write: ex_q.reg_write};
      wb_q  <= '{valid:     mem_q.valid,
                 wb_ctrl:   mem_q.wb_ctrl,
                 dest:      mem_q.dest,
                 reg_write: mem_q.reg_write};
      if (bus.ex_flush || stall_id_c) begin
        ex_q <= BUBBLE_EX;
        if (bubble_q != {CNT_W{1'b1}}) begin
          bubble_q <= bubble_q + CNT_W'(1);
        end
      end else begin
        ex_q <= id_entry;
      end
    end
  end

  // Stage outputs
  assign bus.stall_id     = stall_id_c;
  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_ie_ctrl   = ex_q.ie_ctrl;
  assign bus.ex_mem_ctrl  = ex_q.mem_ctrl;
  assign bus.ex_wb_ctrl   = ex_q.wb_ctrl;
  assign bus.ex_dest      = ex_q.dest;
  assign bus.mem_valid    = mem_q.valid;
  assign bus.mem_mem_ctrl = mem_q.mem_ctrl;
  assign bus.mem_wb_ctrl  = mem_q.wb_ctrl;
  assign bus.mem_dest     = mem_q.dest;
  assign bus.wb_valid     = wb_q.valid;
  assign bus.wb_wb_ctrl   = wb_q.wb_ctrl;
  assign bus.wb_dest      = wb_q.dest;
  assign bus.wb_reg_write = wb_q.valid & wb_q.reg_write & (wb_q.dest != REG_ZERO);
  assign bus.bubble_cnt   = bubble_q;

endmodule
